// File: rtl/rst_sequencer_if.sv
// Bus bundle between the core and the reset/RST sequencer: request, stack-write
// handshake, PC/SP update strobes and completion/abort pulses.
interface rst_sequencer_if #(
  parameter int ADDR_W   = 16,
  parameter int VEC_BITS = 3
) ();
  logic                Start;
  logic                Mode;
  logic [7:0]          Source;
  logic [VEC_BITS-1:0] Int_Vector;
  logic [ADDR_W-1:0]   PC;
  logic [ADDR_W-1:0]   SP;
  logic                Mem_Ready;

  logic                Busy;
  logic                Mem_Write;
  logic [ADDR_W-1:0]   Mem_Addr;
  logic [7:0]          Mem_Data;
  logic                PC_Load;
  logic [ADDR_W-1:0]   PC_New;
  logic                SP_Load;
  logic [ADDR_W-1:0]   SP_New;
  logic                Done;
  logic                Err;

  modport master (
    output Start, Mode, Source, Int_Vector, PC, SP, Mem_Ready,
    input  Busy, Mem_Write, Mem_Addr, Mem_Data, PC_Load, PC_New,
           SP_Load, SP_New, Done, Err
  );

  modport slave (
    input  Start, Mode, Source, Int_Vector, PC, SP, Mem_Ready,
    output Busy, Mem_Write, Mem_Addr, Mem_Data, PC_Load, PC_New,
           SP_Load, SP_New, Done, Err
  );
endinterface

// File: rtl/rst_sequencer.sv
// RST/interrupt entry sequencer: pushes the return PC (high byte first) onto the
// stack, then loads PC with the vector address and SP with the new stack top.
module rst_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int VEC_BITS    = 3,
  parameter int STRIDE_LOG2 = 3,
  parameter int VEC_BASE    = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic CLK,
  input  logic notReset,
  rst_sequencer_if.slave bus
);

  localparam int VW = (VEC_BITS > 3) ? VEC_BITS : 3;

  typedef enum logic [1:0] {IDLE, PUSH_HI, PUSH_LO, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              opcode_ok;
  logic [15:0]       pc_ext;
  logic [31:0]       vec_off;
  logic              mem_write, pc_load, sp_load, done;
  logic [ADDR_W-1:0] mem_addr, pc_new, sp_new;
  logic [7:0]        mem_data;

  always_ff @(posedge CLK) begin
    if (!notReset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // RST opcodes are 11nnn111; nnn selects the vector.
  assign opcode_ok = (bus.Source[7:6] == 2'b11) && (bus.Source[2:0] == 3'b111);
  assign pc_ext    = 16'(pc_q);
  assign vec_off   = 32'(vec_q) << STRIDE_LOG2;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    pc_load   = 1'b0;
    pc_new    = '0;
    sp_load   = 1'b0;
    sp_new    = '0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Mode || opcode_ok) begin
            pc_d    = bus.PC;
            sp_d    = bus.SP;
            vec_d   = bus.Mode ? VW'(bus.Int_Vector) : VW'(bus.Source[5:3]);
            cnt_d   = '0;
            state_d = PUSH_HI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PUSH_HI, PUSH_LO: begin
        mem_write = 1'b1;
        mem_addr  = (state_q == PUSH_HI) ? sp_q - ADDR_W'(1) : sp_q - ADDR_W'(2);
        mem_data  = (state_q == PUSH_HI) ? pc_ext[15:8] : pc_ext[7:0];
        if (bus.Mem_Ready) begin
          cnt_d   = '0;
          state_d = (state_q == PUSH_HI) ? PUSH_LO : LOAD;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Memory never answered: abandon without touching PC/SP.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOAD: begin
        pc_load = 1'b1;
        pc_new  = ADDR_W'(32'(VEC_BASE) + vec_off);
        sp_load = 1'b1;
        sp_new  = sp_q - ADDR_W'(2);
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy      = (state_q != IDLE);
  assign bus.Mem_Write = mem_write;
  assign bus.Mem_Addr  = mem_addr;
  assign bus.Mem_Data  = mem_data;
  assign bus.PC_Load   = pc_load;
  assign bus.PC_New    = pc_new;
  assign bus.SP_Load   = sp_load;
  assign bus.SP_New    = sp_new;
  assign bus.Done      = done;
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: two instances (default vectors and base 0x100/stride 16)
// driven in lockstep, checked against a transaction-level expectation builder.
module tb_rst_sequencer;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic        busy, mw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        pcl;
    logic [15:0] pcn;
    logic        spl;
    logic [15:0] spn;
    logic        done, err;
  } out_t;

  typedef struct {
    bit          rst_n, start, mode;
    logic [7:0]  src;
    logic [2:0]  iv;
    logic [15:0] pc, sp;
    bit          rdy;
    out_t        ea;
    logic [15:0] pcnb;
  } vec_t;

  logic CLK = 1'b0;
  logic notReset = 1'b0;
  always #5 CLK = ~CLK;

  rst_sequencer_if #(.ADDR_W(16), .VEC_BITS(3)) ifa ();
  rst_sequencer_if #(.ADDR_W(16), .VEC_BITS(3)) ifb ();

  assign ifb.Start      = ifa.Start;
  assign ifb.Mode       = ifa.Mode;
  assign ifb.Source     = ifa.Source;
  assign ifb.Int_Vector = ifa.Int_Vector;
  assign ifb.PC         = ifa.PC;
  assign ifb.SP         = ifa.SP;
  assign ifb.Mem_Ready  = ifa.Mem_Ready;

  rst_sequencer u_a (.CLK(CLK), .notReset(notReset), .bus(ifa));
  rst_sequencer #(.STRIDE_LOG2(4), .VEC_BASE(16'h0100)) u_b (.CLK(CLK), .notReset(notReset), .bus(ifb));

  int   n_chk  = 0;
  int   n_fail = 0;
  out_t exq[$];
  logic [15:0] pcnb_exp;
  bit   rdy[64];
  vec_t tbl[7];

  function automatic out_t o_idle(logic e);
    out_t o = '0;
    o.err = e;
    return o;
  endfunction

  function automatic out_t o_wr(logic [15:0] a, logic [7:0] d);
    out_t o = '0;
    o.busy = 1'b1; o.mw = 1'b1; o.addr = a; o.data = d;
    return o;
  endfunction

  function automatic out_t o_load(logic [15:0] pcn, logic [15:0] spn);
    out_t o = '0;
    o.busy = 1'b1; o.pcl = 1'b1; o.pcn = pcn; o.spl = 1'b1; o.spn = spn; o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t get_out(bit sel_b);
    out_t o;
    if (!sel_b) begin
      o = '{ifa.Busy, ifa.Mem_Write, ifa.Mem_Addr, ifa.Mem_Data, ifa.PC_Load, ifa.PC_New,
             ifa.SP_Load, ifa.SP_New, ifa.Done, ifa.Err};
    end else begin
      o = '{ifb.Busy, ifb.Mem_Write, ifb.Mem_Addr, ifb.Mem_Data, ifb.PC_Load, ifb.PC_New,
             ifb.SP_Load, ifb.SP_New, ifb.Done, ifb.Err};
    end
    return o;
  endfunction

  task automatic chk(string nm, out_t ea, logic [15:0] pcnb);
    out_t a, b, eb;
    a  = get_out(1'b0);
    b  = get_out(1'b1);
    eb = ea;
    if (ea.pcl) eb.pcn = pcnb;
    n_chk++;
    if (a !== ea) begin
      n_fail++;
      $display("FAIL %s dutA: got %h expected %h (t=%0t)", nm, a, ea, $time);
    end
    n_chk++;
    if (b !== eb) begin
      n_fail++;
      $display("FAIL %s dutB: got %h expected %h (t=%0t)", nm, b, eb, $time);
    end
  endtask

  // Expected per-cycle outputs after Start is accepted, built from the
  // transaction: run lengths of Mem_Ready=0 decide each push phase.
  task automatic build(bit mode, logic [7:0] src, logic [2:0] iv, logic [15:0] pc, logic [15:0] sp);
    int  pos = 0;
    bit  ok;
    logic [2:0] vec;
    exq.delete();
    pcnb_exp = '0;
    if (!(mode || (src[7:6] == 2'b11 && src[2:0] == 3'b111))) begin
      exq.push_back(o_idle(1'b1));
      return;
    end
    vec = mode ? iv : src[5:3];
    for (int ph = 0; ph < 2; ph++) begin
      ok = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
        exq.push_back(ph == 0 ? o_wr(sp - 16'd1, pc[15:8]) : o_wr(sp - 16'd2, pc[7:0]));
        pos++;
        if (rdy[pos-1]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        exq.push_back(o_idle(1'b1));
        return;
      end
    end
    exq.push_back(o_load(16'(32'(vec) * 8), sp - 16'd2));
    pcnb_exp = 16'(256 + 32'(vec) * 16);
    exq.push_back(o_idle(1'b0));
  endtask

  task automatic run_txn(string nm, bit mode, logic [7:0] src, logic [2:0] iv,
                         logic [15:0] pc, logic [15:0] sp, bit rnd);
    build(mode, src, iv, pc, sp);
    chk({nm, "_pre"}, o_idle(1'b0), 16'h0);
    ifa.Start = 1'b1; ifa.Mode = mode; ifa.Source = src; ifa.Int_Vector = iv;
    ifa.PC = pc; ifa.SP = sp; ifa.Mem_Ready = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < exq.size(); k++) begin
      ifa.Mem_Ready = rdy[k];
      ifa.Start = (exq[k].busy && rnd) ? 1'($urandom) : 1'b0;
      if (exq[k].busy) begin
        ifa.PC = 16'($urandom); ifa.SP = 16'($urandom);
        ifa.Mode = 1'($urandom); ifa.Source = 8'($urandom);
      end
      chk(nm, exq[k], pcnb_exp);
      @(posedge CLK); #1;
    end
    ifa.Start = 1'b0;
  endtask

  initial begin
    ifa.Start = 1'b0; ifa.Mode = 1'b0; ifa.Source = '0; ifa.Int_Vector = '0;
    ifa.PC = '0; ifa.SP = '0; ifa.Mem_Ready = 1'b0;

    // rst_n start mode src iv pc sp rdy | expected A | PC_New of B in LOAD
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 16'h0000, 1'b1, o_idle(1'b0), 16'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'hEF, 3'd0, 16'h1234, 16'h8000, 1'b1, o_wr(16'h7FFF, 8'h12), 16'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'hEF, 3'd0, 16'hFFFF, 16'h0000, 1'b1, o_wr(16'h7FFE, 8'h34), 16'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'hFF, 3'd2, 16'hAAAA, 16'h5555, 1'b1, o_load(16'h0028, 16'h7FFE), 16'h0150};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'hEF, 3'd0, 16'h1111, 16'h2222, 1'b1, o_idle(1'b0), 16'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'hC3, 3'd0, 16'h1111, 16'h2222, 1'b1, o_idle(1'b1), 16'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'hC3, 3'd0, 16'h1111, 16'h2222, 1'b1, o_idle(1'b0), 16'h0};

    for (int i = 0; i < 7; i++) begin
      notReset = tbl[i].rst_n; ifa.Start = tbl[i].start; ifa.Mode = tbl[i].mode;
      ifa.Source = tbl[i].src; ifa.Int_Vector = tbl[i].iv; ifa.PC = tbl[i].pc;
      ifa.SP = tbl[i].sp; ifa.Mem_Ready = tbl[i].rdy;
      @(posedge CLK); #1;
      chk($sformatf("table_row%0d", i), tbl[i].ea, tbl[i].pcnb);
    end
    ifa.Start = 1'b0;

    // interrupt vector 7 with SP wrapping below zero
    foreach (rdy[i]) rdy[i] = 1'b1;
    run_txn("int_vec7_sp_wrap", 1'b1, 8'h00, 3'd7, 16'hBEEF, 16'h0000, 1'b0);

    // three wait cycles in PUSH_HI stretch the write and delay Done
    foreach (rdy[i]) rdy[i] = (i >= 3);
    run_txn("ready_stall3", 1'b0, 8'hEF, 3'd0, 16'h1234, 16'h8000, 1'b0);

    // memory never ready: abort after TIMEOUT wait cycles
    foreach (rdy[i]) rdy[i] = 1'b0;
    run_txn("timeout_hi", 1'b0, 8'hFF, 3'd0, 16'hCAFE, 16'h4000, 1'b1);

    // timeout in PUSH_LO after the high byte went through
    foreach (rdy[i]) rdy[i] = (i == 0);
    run_txn("timeout_lo", 1'b1, 8'h00, 3'd3, 16'h0102, 16'h0001, 1'b1);

    // reset in PUSH_LO with a second Start issued while busy
    ifa.Start = 1'b1; ifa.Mode = 1'b0; ifa.Source = 8'hD7; ifa.PC = 16'h5678;
    ifa.SP = 16'h1000; ifa.Mem_Ready = 1'b1;
    @(posedge CLK); #1;
    chk("rst_seq_hi", o_wr(16'h0FFF, 8'h56), 16'h0);
    ifa.Start = 1'b1;
    @(posedge CLK); #1;
    chk("rst_seq_lo", o_wr(16'h0FFE, 8'h78), 16'h0);
    notReset = 1'b0;
    @(posedge CLK); #1;
    chk("rst_seq_all0", o_idle(1'b0), 16'h0);
    notReset = 1'b1; ifa.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rst_seq_no_done", o_idle(1'b0), 16'h0);
    end

    // random transactions
    for (int t = 0; t < 40; t++) begin
      bit          m;
      logic [7:0]  s;
      int          pat;
      m   = 1'($urandom);
      s   = ($urandom_range(0, 1) == 1) ? {2'b11, 3'($urandom), 3'b111} : 8'($urandom);
      pat = $urandom_range(0, 7);
      foreach (rdy[i]) rdy[i] = (pat == 0) ? 1'b0 : (pat == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      run_txn($sformatf("rand%0d", t), m, s, 3'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
